// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and arbiter-state types for the memory path
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, DACC, IACC} arb_state_t;
  function automatic logic word_match(input word_t a, input word_t b);
    return a[31:2] == b[31:2];
  endfunction
endpackage

// File: rtl/llsc_link.sv
// llsc_link: LL/SC reservation register; hit when the link is live and the word address matches
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set,
  input  logic        clear,
  input  logic [31:0] addr,
  output logic        hit
);
  logic  link_valid_q, link_valid_d;
  word_t link_addr_q, link_addr_d;
  assign link_valid_d = set | (link_valid_q & !clear);
  assign link_addr_d  = set ? addr : link_addr_q;
  assign hit          = link_valid_q & word_match(link_addr_q, addr);
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported RAM between fetch and data, data first, with LL/SC and a watchdog
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);
  arb_state_t state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic err_q, err_d;
  ramstate_t rs;
  logic dreq, dwr, in_dacc, in_iacc, acc, d_done, i_done, sc_fail, timeout, hit;
  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign dwr     = dWEN & !dREN;
  assign in_dacc = state_q == DACC;
  assign in_iacc = state_q == IACC;
  assign acc     = rs == ACCESS;
  assign d_done  = in_dacc & acc & dreq;
  assign i_done  = in_iacc & acc & iREN;
  // A doomed SC is answered straight from IDLE without touching the RAM
  assign sc_fail = state_q == IDLE & dwr & datomic & !hit;
  assign timeout = (in_dacc | in_iacc) & !acc & (wdog_q == CNT_W'(TIMEOUT));
  assign ramREN   = in_dacc ? dREN : in_iacc & iREN;
  assign ramWEN   = in_dacc & dwr;
  assign ramaddr  = in_dacc ? daddr : in_iacc ? iaddr : '0;
  assign ramstore = in_dacc ? dstore : '0;
  assign iwait = iREN & !i_done;
  assign dwait = dreq & !d_done & !sc_fail;
  assign iload = i_done ? ramload : '0;
  assign dload = d_done ? ((datomic & dwr) ? 32'd1 : ramload) : '0;
  assign err   = err_q;
  assign wdog_d = ((in_dacc | in_iacc) & !acc & !timeout) ? wdog_q + CNT_W'(1) : '0;
  assign err_d  = err_q | timeout | ((in_dacc | in_iacc) & rs == ERROR);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = sc_fail ? IDLE : dreq ? DACC : iREN ? IACC : IDLE;
      DACC:    state_d = (!dreq || acc || timeout) ? IDLE : DACC;
      IACC:    state_d = (!iREN || acc || timeout) ? IDLE : IACC;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end
  // Successful SC always hits, so one match-gated clear covers SC and plain stores
  llsc_link u_link (
    .CLK   (CLK),
    .nRST  (nRST),
    .set   (d_done & dREN & datomic),
    .clear (sc_fail | (d_done & dwr & hit)),
    .addr  (daddr),
    .hit   (hit)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for the fetch/data RAM arbiter with LL/SC and watchdog
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  logic        CLK = 1'b0, nRST;
  logic        iREN, dREN, dWEN, datomic;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [1:0]  ramstate;
  int n_vec = 0, n_err = 0;
  always #5 CLK = ~CLK;
  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    nRST = 0; iREN = 1; iaddr = 32'h40; dREN = 0; dWEN = 0; datomic = 0;
    daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    #12;
    chk("rst_iwait", iwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_err", err, 0);
    @(negedge CLK) nRST = 1;
    #2;
    chk("t1_idle_iwait", iwait, 1);
    chk("t1_idle_ramREN", ramREN, 0);
    cyc(); ramstate = ACCESS; ramload = 32'h8C010004; #1;
    chk("t1_ramREN", ramREN, 1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", iwait, 0);
    chk("t1_iload", iload, 32'h8C010004);
    cyc(); ramstate = FREE; #1;
    chk("t1_iwait_after", iwait, 1);
    chk("t1_free_ramREN", ramREN, 0);
    cyc(); iREN = 0; #1;
    chk("drop_ramREN", ramREN, 0);
    cyc(); iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100; #1;
    chk("t2_idle_dwait", dwait, 1);
    chk("t2_idle_iwait", iwait, 1);
    cyc(); ramstate = ACCESS; ramload = 32'hDEAD0100; #1;
    chk("t2_dacc_addr", ramaddr, 32'h100);
    chk("t2_dwait", dwait, 0);
    chk("t2_dload", dload, 32'hDEAD0100);
    chk("t2_iwait_dacc", iwait, 1);
    chk("t2_iload_dacc", iload, 0);
    cyc(); dREN = 0; ramstate = FREE; #1;
    chk("t2_idle2_iwait", iwait, 1);
    cyc(); ramstate = ACCESS; ramload = 32'h11112222; #1;
    chk("t2_iacc_addr", ramaddr, 32'h44);
    chk("t2_iload", iload, 32'h11112222);
    chk("t2_iwait", iwait, 0);
    cyc(); iREN = 0; ramstate = FREE; dREN = 1; datomic = 1; daddr = 32'h200; #1;
    cyc(); ramstate = ACCESS; ramload = 32'h77; #1;
    chk("t3_ll_dload", dload, 32'h77);
    cyc(); ramstate = FREE; dREN = 0; dWEN = 1; dstore = 5; #1;
    chk("t3_sc_idle_dwait", dwait, 1);
    cyc(); ramstate = ACCESS; #1;
    chk("t3_sc_ramWEN", ramWEN, 1);
    chk("t3_sc_ramREN", ramREN, 0);
    chk("t3_sc_ramstore", ramstore, 5);
    chk("t3_sc_addr", ramaddr, 32'h200);
    chk("t3_sc_dload", dload, 1);
    chk("t3_sc_dwait", dwait, 0);
    cyc(); ramstate = FREE; #1;
    chk("t3_sc2_dwait", dwait, 0);
    chk("t3_sc2_dload", dload, 0);
    chk("t3_sc2_ramWEN", ramWEN, 0);
    cyc(); ramstate = ACCESS; #1;
    chk("t3_sc2_stay_idle", ramWEN, 0);
    cyc(); ramstate = FREE; dWEN = 0; dREN = 1; datomic = 1; daddr = 32'h200; #1;
    cyc(); ramstate = ACCESS; #1;
    cyc(); ramstate = FREE; dREN = 0; dWEN = 1; datomic = 0; dstore = 9; #1;
    cyc(); ramstate = ACCESS; #1;
    chk("t4_sw_ramWEN", ramWEN, 1);
    chk("t4_sw_ramstore", ramstore, 9);
    cyc(); ramstate = FREE; datomic = 1; dstore = 5; #1;
    chk("t4_sc_dwait", dwait, 0);
    chk("t4_sc_dload", dload, 0);
    chk("t4_sc_ramWEN", ramWEN, 0);
    cyc(); dWEN = 0; dREN = 1; daddr = 32'h300; #1;
    cyc(); ramstate = ACCESS; #1;
    cyc(); ramstate = FREE; dREN = 0; dWEN = 1; daddr = 32'h304; #1;
    chk("t4_sc_nextword_fail", dwait, 0);
    cyc(); dWEN = 0; dREN = 1; daddr = 32'h300; #1;
    cyc(); ramstate = ACCESS; #1;
    cyc(); ramstate = FREE; dREN = 0; dWEN = 1; daddr = 32'h302; #1;
    chk("t4_sc_sameword_hit", dwait, 1);
    cyc(); ramstate = ACCESS; #1;
    chk("t4_sc_sameword_dload", dload, 1);
    cyc(); ramstate = BUSY; dWEN = 0; datomic = 0; dREN = 1; daddr = 32'h400; #1;
    cyc();
    repeat (256) cyc();
    chk("t5_err_before", err, 0);
    chk("t5_still_dacc", ramREN, 1);
    cyc();
    chk("t5_err", err, 1);
    chk("t5_idle_ramREN", ramREN, 0);
    chk("t5_dwait", dwait, 1);
    cyc(); dREN = 0; ramstate = FREE; #1;
    cyc(); dREN = 1; datomic = 1; daddr = 32'h500; #1;
    cyc(); ramstate = ACCESS; #1;
    cyc(); ramstate = BUSY; dREN = 0; datomic = 0; iREN = 1; iaddr = 32'h80; #1;
    cyc();
    chk("t6_iacc_ramREN", ramREN, 1);
    nRST = 0; #1;
    chk("t6_rst_ramREN", ramREN, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_iwait", iwait, 1);
    @(negedge CLK) nRST = 1; iREN = 0;
    cyc(); ramstate = FREE; dWEN = 1; datomic = 1; daddr = 32'h500; dstore = 3; #1;
    chk("t6_link_lost_dwait", dwait, 0);
    chk("t6_link_lost_ramWEN", ramWEN, 0);
    cyc(); dWEN = 0; datomic = 0; dREN = 1; daddr = 32'h600; #1;
    cyc(); ramstate = ERROR; #1;
    chk("ramerr_pre", err, 0);
    cyc(); dREN = 0; ramstate = FREE; #1;
    chk("ramerr_err", err, 1);
    cyc();
    chk("ramerr_sticky", err, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
